btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer for the fetch stage. Each cycle it looks up one 8-byte fetch group (two 4-byte slots) and returns a predicted target one cycle later. It is trained from the branch-resolve path, supports targeted invalidation on mispredict, and supports a full flush. It replaces the direct-mapped, full-tag BTB with configurable ways, partial tags and per-set replacement.

---
 rtl/btb_pkg.sv | 21 ++
 rtl/btb_assoc_if.sv | 20 ++
 rtl/btb_way.sv | 64 ++++++
 rtl/btb_assoc.sv | 126 ++++++++++++
 tb/tb_btb_assoc.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared BTB configuration defaults, entry layout and sizing helper.
package btb_pkg;
  localparam int BTB_ADDR_LEN = 32;
  localparam int BTB_IDX_SEL  = 3;   // index starts above the 8-byte fetch group offset
  localparam int BTB_IDX_NUM  = 6;
  localparam int BTB_TAG_BITS = 16;
  localparam int BTB_WAYS     = 2;

  // One BTB entry at the default configuration.
  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic                    slot;
    logic [BTB_ADDR_LEN-1:0] target;
  } btb_entry_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup, resolve-side train/invalidate and flush signals of the BTB.
interface btb_assoc_if #(parameter int ADDR_LEN = 32);
  logic                lookup_en;
  logic [ADDR_LEN-1:0] pc;
  logic                invalid2;
  logic                hit;
  logic                hit_slot1;
  logic [ADDR_LEN-1:0] jmpaddr;
  logic                we;
  logic [ADDR_LEN-1:0] jmpsrc;
  logic [ADDR_LEN-1:0] jmpdst;
  logic                inv;
  logic [ADDR_LEN-1:0] inv_src;
  logic                flush;

  modport master (output lookup_en, pc, invalid2, we, jmpsrc, jmpdst, inv, inv_src, flush,
                  input  hit, hit_slot1, jmpaddr);
  modport slave  (input  lookup_en, pc, invalid2, we, jmpsrc, jmpdst, inv, inv_src, flush,
                  output hit, hit_slot1, jmpaddr);
endinterface

// File: rtl/btb_way.sv
// One BTB way: valid flops plus tag/slot/target arrays, with a lookup read port
// and tag+slot probes for the train and invalidate addresses.
module btb_way import btb_pkg::*; #(
  parameter int ADDR_LEN = BTB_ADDR_LEN,
  parameter int IDX_BITS = BTB_IDX_NUM,
  parameter int TAG_BITS = BTB_TAG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_flush,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic                o_rd_valid,
  output logic [TAG_BITS-1:0] o_rd_tag,
  output logic                o_rd_slot,
  output logic [ADDR_LEN-1:0] o_rd_target,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0] i_wr_tag,
  input  logic                i_wr_slot,
  input  logic [ADDR_LEN-1:0] i_wr_target,
  input  logic                i_we,
  output logic                o_wr_valid,
  output logic                o_wr_match,
  input  logic [IDX_BITS-1:0] i_inv_idx,
  input  logic [TAG_BITS-1:0] i_inv_tag,
  input  logic                i_inv_slot,
  input  logic                i_inv,
  output logic                o_inv_match
);
  localparam int SETS = 1 << IDX_BITS;

  logic [SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag    [SETS];
  logic                r_slot   [SETS];
  logic [ADDR_LEN-1:0] r_target [SETS];

  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_slot   = r_slot[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];

  assign o_wr_valid  = r_valid[i_wr_idx];
  assign o_wr_match  = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag) &&
                       (r_slot[i_wr_idx] == i_wr_slot);
  assign o_inv_match = r_valid[i_inv_idx] && (r_tag[i_inv_idx] == i_inv_tag) &&
                       (r_slot[i_inv_idx] == i_inv_slot);

  // Valid bits: flush clears all; a train lands after the invalidate so it wins on the same entry.
  always_ff @(posedge clk) begin
    if (reset || i_flush) r_valid <= '0;
    else begin
      if (i_inv) r_valid[i_inv_idx] <= 1'b0;
      if (i_we)  r_valid[i_wr_idx]  <= 1'b1;
    end
  end

  // Entry payload; contents are don't-care while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_slot[i_wr_idx]   <= i_wr_slot;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: WAYS x btb_way, way match/select, per-set round-robin
// replacement and a registered one-cycle lookup result.
module btb_assoc import btb_pkg::*; #(
  parameter int ADDR_LEN = BTB_ADDR_LEN,
  parameter int IDX_BITS = BTB_IDX_NUM,
  parameter int WAYS     = BTB_WAYS,
  parameter int TAG_BITS = BTB_TAG_BITS
) (
  input  logic       clk,
  input  logic       reset,
  btb_assoc_if.slave bus
);
  localparam int SETS    = 1 << IDX_BITS;
  localparam int RRW     = clog2_min1(WAYS);
  localparam int TAG_LSB = BTB_IDX_SEL + IDX_BITS;

  logic [IDX_BITS-1:0] w_rd_idx, w_wr_idx, w_inv_idx;
  logic [TAG_BITS-1:0] w_pc_tag, w_wr_tag, w_inv_tag;
  logic [WAYS-1:0]     w_rd_valid, w_rd_slot, w_wr_valid, w_wr_match, w_inv_match;
  logic [WAYS-1:0]     w_way_we, w_way_inv, w_eq, w_exact, w_match, w_wr_sel;
  logic [WAYS-1:0][TAG_BITS-1:0] w_rd_tag;
  logic [WAYS-1:0][ADDR_LEN-1:0] w_rd_tgt;
  logic                w_hit, w_slot, w_victim, w_unused;
  logic [ADDR_LEN-1:0] w_tgt;
  logic [RRW-1:0]      w_rr_cur;
  logic                r_hit, r_slot;
  logic [ADDR_LEN-1:0] r_tgt;

  assign w_rd_idx  = bus.pc[BTB_IDX_SEL +: IDX_BITS];
  assign w_pc_tag  = bus.pc[TAG_LSB +: TAG_BITS];
  assign w_wr_idx  = bus.jmpsrc[BTB_IDX_SEL +: IDX_BITS];
  assign w_wr_tag  = bus.jmpsrc[TAG_LSB +: TAG_BITS];
  assign w_inv_idx = bus.inv_src[BTB_IDX_SEL +: IDX_BITS];
  assign w_inv_tag = bus.inv_src[TAG_LSB +: TAG_BITS];
  // Address bits outside offset/index/tag are intentionally ignored.
  assign w_unused  = ^{bus.pc, bus.jmpsrc, bus.inv_src};

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    btb_way #(.ADDR_LEN(ADDR_LEN), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) u_way (
      .clk        (clk),          .reset      (reset),          .i_flush   (bus.flush),
      .i_rd_idx   (w_rd_idx),     .o_rd_valid (w_rd_valid[g]),  .o_rd_tag  (w_rd_tag[g]),
      .o_rd_slot  (w_rd_slot[g]), .o_rd_target(w_rd_tgt[g]),
      .i_wr_idx   (w_wr_idx),     .i_wr_tag   (w_wr_tag),       .i_wr_slot (bus.jmpsrc[2]),
      .i_wr_target(bus.jmpdst),   .i_we       (w_way_we[g]),    .o_wr_valid(w_wr_valid[g]),
      .o_wr_match (w_wr_match[g]),
      .i_inv_idx  (w_inv_idx),    .i_inv_tag  (w_inv_tag),      .i_inv_slot(bus.inv_src[2]),
      .i_inv      (w_way_inv[g]), .o_inv_match(w_inv_match[g])
    );
  end

  // Way match and select: exact-slot match first, else lowest-numbered match.
  always_comb begin
    w_hit = 1'b0;
    w_slot = 1'b0;
    w_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_eq[w]    = w_rd_valid[w] && (w_rd_tag[w] == w_pc_tag);
      w_exact[w] = w_eq[w] && (w_rd_slot[w] == bus.pc[2]);
      w_match[w] = w_exact[w] || (w_eq[w] && !bus.pc[2] && w_rd_slot[w] && !bus.invalid2);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (w_match[w]) begin
        w_hit = 1'b1; w_slot = w_rd_slot[w]; w_tgt = w_rd_tgt[w];
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (w_exact[w]) begin
        w_hit = 1'b1; w_slot = w_rd_slot[w]; w_tgt = w_rd_tgt[w];
      end
    end
  end

  // Train target: existing tag+slot entry, else lowest invalid way, else round-robin victim.
  always_comb begin
    w_wr_sel = '0;
    if (|w_wr_match) begin
      for (int w = WAYS-1; w >= 0; w--) begin
        if (w_wr_match[w]) begin w_wr_sel = '0; w_wr_sel[w] = 1'b1; end
      end
    end else if (!(&w_wr_valid)) begin
      for (int w = WAYS-1; w >= 0; w--) begin
        if (!w_wr_valid[w]) begin w_wr_sel = '0; w_wr_sel[w] = 1'b1; end
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_rr_cur == RRW'(w)) w_wr_sel[w] = 1'b1;
      end
    end
  end

  assign w_victim  = bus.we && !bus.flush && !(|w_wr_match) && (&w_wr_valid);
  assign w_way_we  = (bus.we && !bus.flush) ? w_wr_sel : '0;
  assign w_way_inv = (bus.inv && !bus.flush) ? w_inv_match : '0;

  if (WAYS > 1) begin : g_rr
    logic [RRW-1:0] r_rr [SETS];
    assign w_rr_cur = r_rr[w_wr_idx];
    // Per-set round-robin pointer; moves only when a valid way is evicted.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SETS; i++) r_rr[i] <= '0;
      end else if (w_victim) begin
        r_rr[w_wr_idx] <= r_rr[w_wr_idx] + 1'b1;
      end
    end
  end else begin : g_no_rr
    assign w_rr_cur = '0;
  end

  // Lookup result register; lookup_en=0 holds the previous prediction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit  <= 1'b0;
      r_slot <= 1'b0;
      r_tgt  <= '0;
    end else if (bus.lookup_en) begin
      r_hit  <= w_hit;
      r_slot <= w_slot;
      r_tgt  <= w_tgt;
    end
  end

  assign bus.hit       = r_hit;
  assign bus.hit_slot1 = r_slot;
  assign bus.jmpaddr   = r_tgt;
endmodule

// File: tb/tb_btb_assoc.sv
// Table-driven scoreboard bench for btb_assoc (default 2-way, 64-set configuration).
module tb_btb_assoc;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btb_assoc_if #(.ADDR_LEN(32)) bus();
  btb_assoc #(.ADDR_LEN(32), .IDX_BITS(6), .WAYS(2), .TAG_BITS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic lk; logic [31:0] pc; logic inv2;
    logic we; logic [31:0] src; logic [31:0] dst;
    logic inv; logic [31:0] isrc; logic fl;
    logic eh; logic es; logic [31:0] et;
  } vec_t;

  typedef struct {
    logic h; logic s; logic [31:0] t; logic strict; string nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] P0 = 32'h1000, P4 = 32'h1004;
  localparam logic [31:0] A = 32'h10008, B = 32'h20008, C = 32'h30008;
  localparam logic [31:0] D = 32'h40008, E = 32'h50008, F = 32'h60008;

  task automatic add(input logic lk, input logic [31:0] pc, input logic inv2,
                     input logic we, input logic [31:0] src, input logic [31:0] dst,
                     input logic inv, input logic [31:0] isrc, input logic fl,
                     input logic eh, input logic es, input logic [31:0] et);
    vec_t v;
    v.lk = lk; v.pc = pc; v.inv2 = inv2; v.we = we; v.src = src; v.dst = dst;
    v.inv = inv; v.isrc = isrc; v.fl = fl; v.eh = eh; v.es = es; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sbq.pop_front();
    checks++;
    if (bus.hit !== e.h ||
        ((e.h || e.strict) && (bus.hit_slot1 !== e.s || bus.jmpaddr !== e.t))) begin
      errors++;
      $display("FAIL %s: got hit=%0b slot1=%0b addr=%h, want hit=%0b slot1=%0b addr=%h",
               e.nm, bus.hit, bus.hit_slot1, bus.jmpaddr, e.h, e.s, e.t);
    end
  endtask

  task automatic cyc(input logic rst, input logic lk, input logic [31:0] pc, input logic inv2,
                     input logic we, input logic [31:0] src, input logic [31:0] dst,
                     input logic inv, input logic [31:0] isrc, input logic fl,
                     input logic eh, input logic es, input logic [31:0] et,
                     input logic strict, input string nm);
    @(negedge clk);
    reset = rst; bus.lookup_en = lk; bus.pc = pc; bus.invalid2 = inv2;
    bus.we = we; bus.jmpsrc = src; bus.jmpdst = dst;
    bus.inv = inv; bus.inv_src = isrc; bus.flush = fl;
    sbq.push_back('{eh, es, et, strict, nm});
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.lookup_en = 0; bus.pc = '0; bus.invalid2 = 0; bus.we = 0; bus.jmpsrc = '0;
    bus.jmpdst = '0; bus.inv = 0; bus.inv_src = '0; bus.flush = 0;
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back('{1'b0, 1'b0, 32'h0, 1'b1, "reset_state"});
    check_out();

    //   lk pc  i2 we src dst       inv isrc fl  eh es et
    add(1, P0, 0, 0, 0,  0,        0, 0,  0,  0, 0, 0);         // empty miss
    add(1, P0, 0, 1, P0, 'h2000,   0, 0,  0,  0, 0, 0);         // same-cycle train not seen
    add(1, P0, 0, 0, 0,  0,        0, 0,  0,  1, 0, 'h2000);
    add(0, 0,  0, 1, P4, 'h3000,   0, 0,  0,  1, 0, 'h2000);    // lookup_en=0 holds
    add(1, P0, 0, 0, 0,  0,        0, 0,  0,  1, 0, 'h2000);    // exact slot preferred
    add(1, P4, 0, 0, 0,  0,        0, 0,  0,  1, 1, 'h3000);
    add(1, P0, 0, 0, 0,  0,        1, P0, 0,  1, 0, 'h2000);    // inv read-before-write
    add(1, P0, 0, 0, 0,  0,        0, 0,  0,  1, 1, 'h3000);    // slot1 via pc+4
    add(1, P0, 1, 0, 0,  0,        0, 0,  0,  0, 0, 0);         // invalid2 masks slot1
    add(1, P4, 0, 0, 0,  0,        1, 'h2000, 0, 1, 1, 'h3000); // inv miss
    add(1, P4, 0, 0, 0,  0,        0, 0,  0,  1, 1, 'h3000);
    add(1, P0, 0, 1, P0, 'h2100,   0, 0,  0,  1, 1, 'h3000);
    add(1, P0, 0, 0, 0,  0,        0, 0,  0,  1, 0, 'h2100);
    add(1, P4, 0, 1, P4, 'h3300,   1, P0, 0,  1, 1, 'h3000);    // we+inv different ways
    add(1, P4, 0, 0, 0,  0,        0, 0,  0,  1, 1, 'h3300);
    add(1, P0, 1, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(0, 0,  0, 1, A,  'hA000,   0, 0,  0,  0, 0, 0);         // aliasing set 1
    add(1, A,  0, 1, B,  'hB000,   0, 0,  0,  1, 0, 'hA000);
    add(1, B,  0, 1, C,  'hC000,   0, 0,  0,  1, 0, 'hB000);    // C evicts A
    add(1, A,  0, 1, D,  'hD000,   0, 0,  0,  0, 0, 0);         // D evicts B
    add(1, B,  0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(1, C,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hC000);
    add(1, D,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hD000);
    add(1, D,  0, 1, E,  'hE000,   0, 0,  0,  1, 0, 'hD000);    // rr wraps, E evicts C
    add(1, C,  0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(1, E,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hE000);
    add(1, E,  0, 1, E,  'hE100,   1, E,  0,  1, 0, 'hE000);    // we+inv same entry
    add(1, E,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hE100);
    add(0, 0,  0, 1, F,  'hF000,   0, 0,  0,  1, 0, 'hE100);    // overwrite left rr alone
    add(1, D,  0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(1, E,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hE100);
    add(1, F,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hF000);
    add(1, F,  0, 0, 0,  0,        0, 0,  1,  1, 0, 'hF000);    // flush: old result
    add(1, F,  0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(1, E,  0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(1, P4, 0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(0, 0,  0, 1, F,  'hF100,   0, 0,  0,  0, 0, 0);
    add(1, F,  0, 0, 0,  0,        0, 0,  0,  1, 0, 'hF100);    // hits resume
    add(1, F,  0, 1, P4, 'h3000,   0, 0,  1,  1, 0, 'hF100);    // flush beats we
    add(1, P4, 0, 0, 0,  0,        0, 0,  0,  0, 0, 0);
    add(1, F,  0, 0, 0,  0,        0, 0,  0,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(0, vecs[i].lk, vecs[i].pc, vecs[i].inv2, vecs[i].we, vecs[i].src, vecs[i].dst,
          vecs[i].inv, vecs[i].isrc, vecs[i].fl, vecs[i].eh, vecs[i].es, vecs[i].et,
          1'b0, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a stream drops the pending result and clears entries.
    cyc(0, 1, P0, 0, 1, P0, 'h2000, 0, 0, 0, 0, 0, 0,       0, "rst_train");
    cyc(0, 1, P0, 0, 0, 0,  0,      0, 0, 0, 1, 0, 'h2000, 0, "rst_pre_hit");
    cyc(1, 1, P0, 0, 0, 0,  0,      0, 0, 0, 0, 0, 0,       1, "rst_mid");
    cyc(0, 1, P0, 0, 0, 0,  0,      0, 0, 0, 0, 0, 0,       0, "rst_cleared");
    cyc(0, 0, 0,  0, 0, 0,  0,      0, 0, 0, 0, 0, 0,       0, "rst_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
